// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronise, glitch-filter, deserialise, check.
// Define PS2_RX_PARITY_CHECK_EN to enforce odd parity; otherwise the parity bit is ignored.
module ps2_frame_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iInhibit,
  input  logic       iPs2Clk,
  input  logic       iPs2Dat,
  output logic       oPs2Clk,
  output logic       oPs2Dat,
  output logic       oRx,
  output logic [7:0] oRxData,
  output logic       oErr
);

  localparam int FW       = $clog2(FILTER_LEN + 1);
  localparam int TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int MASK_LEN = FILTER_LEN + 3;
  localparam int MW       = $clog2(MASK_LEN + 1);

  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

  state_t        state_q, state_d;
  logic          csync1_q, csync1_d, csync2_q, csync2_d;
  logic          dsync1_q, dsync1_d, dsync2_q, dsync2_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fclk_q, fclk_d, fprev_q, fprev_d;
  logic          pclk_q, pclk_d;
  logic [MW-1:0] mask_q, mask_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [9:0]    shreg_q, shreg_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          rx_q, rx_d, err_q, err_d;
  logic [7:0]    data_q, data_d;
  logic          hold, fall, par_ok;

  always_comb begin
    csync1_d = iPs2Clk;
    csync2_d = csync1_q;
    dsync1_d = iPs2Dat;
    dsync2_d = dsync1_q;
    fclk_d   = fclk_q;
    fcnt_d   = '0;
    if (csync2_q != fclk_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) fclk_d = csync2_q;
      else fcnt_d = fcnt_q + 1'b1;
    end
    fprev_d = fclk_q;
    pclk_d  = ~iInhibit;
    // Keep masking until our own pull-down has drained out of sync + filter
    if (!pclk_q) mask_d = MW'(MASK_LEN);
    else if (mask_q != '0) mask_d = mask_q - 1'b1;
    else mask_d = mask_q;
  end

  assign hold = iInhibit | ~pclk_q | (mask_q != '0);
  assign fall = fprev_q & ~fclk_q & ~hold;

`ifdef PS2_RX_PARITY_CHECK_EN
  assign par_ok = ^shreg_q[8:0];
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    tcnt_d   = tcnt_q;
    rx_d     = 1'b0;
    err_d    = 1'b0;
    data_d   = data_q;
    unique case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (fall && !dsync2_q) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shreg_d  = {dsync2_q, shreg_q[9:1]};
          tcnt_d   = '0;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd9) state_d = CHECK;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (shreg_q[9] && par_ok) begin
          rx_d   = 1'b1;
          data_d = shreg_q[7:0];
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (hold) begin
      state_d = IDLE;
      rx_d    = 1'b0;
      err_d   = 1'b0;
      data_d  = data_q;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= IDLE;
      csync1_q <= 1'b1;
      csync2_q <= 1'b1;
      dsync1_q <= 1'b1;
      dsync2_q <= 1'b1;
      fcnt_q   <= '0;
      fclk_q   <= 1'b1;
      fprev_q  <= 1'b1;
      pclk_q   <= 1'b1;
      mask_q   <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      tcnt_q   <= '0;
      rx_q     <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      csync1_q <= csync1_d;
      csync2_q <= csync2_d;
      dsync1_q <= dsync1_d;
      dsync2_q <= dsync2_d;
      fcnt_q   <= fcnt_d;
      fclk_q   <= fclk_d;
      fprev_q  <= fprev_d;
      pclk_q   <= pclk_d;
      mask_q   <= mask_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      tcnt_q   <= tcnt_d;
      rx_q     <= rx_d;
      err_q    <= err_d;
      data_q   <= data_d;
    end
  end

  assign oPs2Clk = pclk_q;
  assign oPs2Dat = 1'b1;
  assign oRx     = rx_q;
  assign oErr    = err_q;
  assign oRxData = data_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Bench for ps2_frame_rx: directed frame table, corner sequences, random frames vs model.
module tb_ps2_frame_rx;
  localparam int FL = 8;
  localparam int TO = 25000;
  localparam int H  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inh = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       line_clk;
  logic       o_clk, o_dat, o_rx, o_err;
  logic [7:0] o_data;

  // Open-drain bus: either side can pull the clock low
  assign line_clk = dev_clk & o_clk;

  ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .iClk(clk), .iRst(rst), .iInhibit(inh),
    .iPs2Clk(line_clk), .iPs2Dat(dev_dat),
    .oPs2Clk(o_clk), .oPs2Dat(o_dat),
    .oRx(o_rx), .oRxData(o_data), .oErr(o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int rx_cnt = 0;
  int err_cnt = 0;
  int last_fall = 0;
  int strobe_cyc = 0;
  logic [7:0] last_data = 8'h00;
  logic prev_rx = 1'b0;
  logic prev_err = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (o_rx || o_err) begin
        check("rx_err_overlap", int'(o_rx && o_err), 0);
        check("strobe_width", int'((o_rx && prev_rx) || (o_err && prev_err)), 0);
        strobe_cyc = cyc;
      end
      if (o_rx) begin
        rx_cnt++;
        last_data = o_data;
      end
      if (o_err) err_cnt++;
      prev_rx  = o_rx;
      prev_err = o_err;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par,
                            input logic stop, input int nbits, input bit glitch);
    logic [10:0] b;
    b = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dev_dat = b[i];
      if (glitch && (i % 3 == 1)) begin
        tick(5);
        dev_clk = 1'b0;
        tick(3);
        dev_clk = 1'b1;
        tick(H - 8);
      end else begin
        tick(H);
      end
      dev_clk   = 1'b0;
      last_fall = cyc;
      tick(H);
      dev_clk = 1'b1;
    end
    dev_dat = 1'b1;
    tick(2 * H);
  endtask

  task automatic frame_check(input string name, input logic [7:0] d, input logic par,
                             input logic stop, input bit glitch,
                             input bit exp_rx, input logic [7:0] exp_data);
    int r0 = rx_cnt;
    int e0 = err_cnt;
    send_frame(d, par, stop, 11, glitch);
    check({name, "_rx"}, rx_cnt - r0, int'(exp_rx));
    check({name, "_err"}, err_cnt - e0, int'(!exp_rx));
    if (exp_rx) check({name, "_data"}, int'(last_data), int'(exp_data));
  endtask

  function automatic bit model_ok(input logic [7:0] d, input logic par, input logic stop);
    int ones = $countones({d, par});
`ifdef PS2_RX_PARITY_CHECK_EN
    return stop && (ones % 2 == 1);
`else
    return stop && (ones >= 0);
`endif
  endfunction

  typedef struct {
    string      name;
    logic [7:0] d;
    logic       par;
    logic       stop;
    bit         glitch;
    bit         exp_rx;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int r0, e0, d;
    logic [7:0] rd;
    logic rp, rs;
    bit rg, ok;

    tbl[0] = '{"f1c",   8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C};
    tbl[1] = '{"ff0",   8'hF0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hF0};
    tbl[2] = '{"f1c_b", 8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h1C};
`ifdef PS2_RX_PARITY_CHECK_EN
    tbl[3] = '{"badpar", 8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
`else
    tbl[3] = '{"badpar", 8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1C};
`endif
    tbl[4] = '{"stop0", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[5] = '{"f12",   8'h12, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12};
    tbl[6] = '{"glitch", 8'h29, 1'b0, 1'b1, 1'b1, 1'b1, 8'h29};

    tick(3);
    check("rst_rx", int'(o_rx), 0);
    check("rst_err", int'(o_err), 0);
    check("rst_data", int'(o_data), 0);
    check("rst_ps2clk", int'(o_clk), 1);
    check("rst_ps2dat", int'(o_dat), 1);
    rst = 1'b0;
    tick(5);

    for (int i = 0; i < 7; i++) begin
      frame_check(tbl[i].name, tbl[i].d, tbl[i].par, tbl[i].stop,
                  tbl[i].glitch, tbl[i].exp_rx, tbl[i].exp_data);
      if (i == 0) begin
        d = strobe_cyc - last_fall;
        // 2 sync flops + FILTER_LEN filter + 2-cycle check latency
        check("latency", int'(d >= 11 && d <= 13), 1);
      end
    end

    r0 = rx_cnt;
    e0 = err_cnt;
    send_frame(8'hA5, 1'b1, 1'b1, 5, 1'b0);
    tick(TO + 2);
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_rx", rx_cnt - r0, 0);
    frame_check("after_to", 8'h76, 1'b0, 1'b1, 1'b0, 1'b1, 8'h76);

    r0 = rx_cnt;
    e0 = err_cnt;
    send_frame(8'h29, 1'b0, 1'b1, 5, 1'b0);
    inh = 1'b1;
    tick(1);
    check("inhibit_clk", int'(o_clk), 0);
    tick(200);
    inh = 1'b0;
    tick(1);
    check("release_clk", int'(o_clk), 1);
    tick(100);
    check("inhibit_rx", rx_cnt - r0, 0);
    check("inhibit_err", err_cnt - e0, 0);
    frame_check("after_inh", 8'h29, 1'b0, 1'b1, 1'b0, 1'b1, 8'h29);

    r0 = rx_cnt;
    e0 = err_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 6, 1'b0);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(20);
    check("midrst_rx", rx_cnt - r0, 0);
    check("midrst_err", err_cnt - e0, 0);
    frame_check("after_rst", 8'h45, 1'b0, 1'b1, 1'b0, 1'b1, 8'h45);

    for (int i = 0; i < 30; i++) begin
      rd = 8'($urandom);
      rp = ($urandom_range(0, 4) != 0) ? ~^rd : ^rd;
      rs = ($urandom_range(0, 9) != 0);
      rg = ($urandom_range(0, 3) == 0);
      ok = model_ok(rd, rp, rs);
      frame_check("rand", rd, rp, rs, rg, ok, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
